// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 multiplexed output channel between
// requesters A and B. A grant is held for a burst that ends on a last-beat
// flag, the MAX_BURST beat limit, or the requester withdrawing; ownership
// then passes to the other side, with no idle cycle if it is already waiting.
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high; out_valid only rises for the granted requester's req, and
// sel (hence out_data) holds while out_valid is high and out_ready is low.
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             last_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             last_b,
    input  logic             out_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Beat index that closes a burst when reached without a last flag.
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       ptr_q, ptr_d;        // 0 = A has priority, 1 = B
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       beat;

    assign gnt_a     = (state_q == GRANT_A);
    assign gnt_b     = (state_q == GRANT_B);
    assign busy      = gnt_a | gnt_b;
    assign sel       = sel_q;
    assign out_data  = sel_q ? data_b : data_a;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign beat      = out_valid & out_ready;

    // State, select, priority pointer and burst counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            ptr_q       <= 1'b0;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state: arbitration from IDLE, burst tracking and release/handover.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && (!req_b || !ptr_q)) begin
                    state_d = GRANT_A;
                    sel_d   = 1'b0;
                end else if (req_b) begin
                    state_d = GRANT_B;
                    sel_d   = 1'b1;
                end
            end
            GRANT_A: begin
                if (!req_a || (beat && (last_a || burst_cnt_q == LAST_CNT))) begin
                    burst_cnt_d = 8'd0;
                    ptr_d       = 1'b1;
                    if (req_b) begin
                        state_d = GRANT_B;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            GRANT_B: begin
                if (!req_b || (beat && (last_b || burst_cnt_q == LAST_CNT))) begin
                    burst_cnt_d = 8'd0;
                    ptr_d       = 1'b0;
                    if (req_a) begin
                        state_d = GRANT_A;
                        sel_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic.
// A behavioural model tracks channel ownership; every beat the model expects
// is queued, and a monitor pops it when the DUT presents an accepted beat.
module tb_rr_mux_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk, rst;
  logic         req_a, last_a, req_b, last_b, out_ready;
  logic [W-1:0] data_a, data_b;
  logic         gnt_a, gnt_b, sel, out_valid, busy;
  logic [W-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  // Expected beats: {source (0=A,1=B), data}.
  logic [W:0] exp_q[$];

  // Model: owner -1 = nobody, 0 = A, 1 = B.
  int   m_owner, m_turn, m_beats;
  logic m_sel;
  int   n_owner, n_turn, n_beats;
  logic n_sel;

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b),
    .out_ready(out_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_turn = 0; m_beats = 0; m_sel = 1'b0;
    n_owner = -1; n_turn = 0; n_beats = 0; n_sel = 1'b0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    req_a = 0; req_b = 0; last_a = 0; last_b = 0; out_ready = 0;
    data_a = '0; data_b = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs and compute what the channel should do.
  task automatic drive(input logic ra, input logic [W-1:0] da, input logic la,
                       input logic rb, input logic [W-1:0] db, input logic lb,
                       input logic rdy);
    logic         r[2];
    logic         l[2];
    logic [W-1:0] d[2];
    int           oth;
    logic         beat;
    req_a = ra; data_a = da; last_a = la;
    req_b = rb; data_b = db; last_b = lb;
    out_ready = rdy;
    r[0] = ra; r[1] = rb; l[0] = la; l[1] = lb; d[0] = da; d[1] = db;
    n_owner = m_owner; n_turn = m_turn; n_beats = m_beats; n_sel = m_sel;
    if (m_owner < 0) begin
      if (r[0] && r[1]) n_owner = m_turn;
      else if (r[0])    n_owner = 0;
      else if (r[1])    n_owner = 1;
      if (n_owner >= 0) n_sel = (n_owner == 1);
    end else begin
      oth  = 1 - m_owner;
      beat = r[m_owner] && rdy;
      if (beat) exp_q.push_back({m_owner[0], d[m_owner]});
      if (!r[m_owner] || (beat && (l[m_owner] || m_beats + 1 == MB))) begin
        n_beats = 0;
        n_turn  = oth;
        if (r[oth]) begin
          n_owner = oth;
          n_sel   = (oth == 1);
        end else begin
          n_owner = -1;
        end
      end else if (beat) begin
        n_beats = m_beats + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    m_owner = n_owner; m_turn = n_turn; m_beats = n_beats; m_sel = n_sel;
  endtask

  task automatic cycle(input logic ra, input logic [W-1:0] da, input logic la,
                       input logic rb, input logic [W-1:0] db, input logic lb,
                       input logic rdy);
    drive(ra, da, la, rb, db, lb, rdy);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("gnt_a", gnt_a, m_owner == 0);
        chk("gnt_b", gnt_b, m_owner == 1);
        chk("busy", busy, m_owner >= 0);
        chk("sel", sel, m_sel);
        chk("out_data", out_data, m_sel ? data_b : data_a);
        chk("out_valid", out_valid, (m_owner == 0 && req_a) || (m_owner == 1 && req_b));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {sel, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {sel, out_data}, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A single-beat burst, then back to idle.
    cycle(1, 8'h11, 1, 0, 8'h00, 0, 1);
    cycle(1, 8'h11, 1, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    chk("a_done_idle", busy, 0);

    // Both held, no last: bursts of MAX_BURST alternating with no idle gap.
    for (int i = 0; i < 20; i++) cycle(1, 8'(8'hA0 + i), 0, 1, 8'(8'hB0 + i), 0, 1);
    do_reset();

    // B under backpressure for 3 cycles, then the beat goes through.
    cycle(0, 8'h00, 0, 1, 8'h5A, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1, 8'h5A, 0, 0);
    chk("bp_gnt_b", gnt_b, 1);
    cycle(0, 8'h00, 0, 1, 8'h5A, 1, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    do_reset();

    // A withdraws after 2 beats while B waits: immediate handover.
    cycle(1, 8'h01, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h02, 0, 1, 8'h20, 0, 1);
    cycle(1, 8'h03, 0, 1, 8'h21, 0, 1);
    cycle(0, 8'h00, 0, 1, 8'h22, 0, 1);
    chk("abort_gnt_b", gnt_b, 1);
    chk("abort_sel", sel, 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 1, 8'(8'h30 + i), 0, 1);
    do_reset();

    // Simultaneous requests after reset: A first, then B on re-request.
    cycle(1, 8'h44, 0, 1, 8'h55, 0, 1);
    cycle(1, 8'h44, 1, 1, 8'h55, 0, 0);
    cycle(1, 8'h45, 1, 1, 8'h56, 0, 1);
    chk("rr_gnt_b", gnt_b, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h46, 0, 1, 8'h57, 0, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    do_reset();

    // Asynchronous reset mid-burst in GRANT_B.
    cycle(0, 8'h00, 0, 1, 8'h77, 0, 1);
    cycle(0, 8'h00, 0, 1, 8'h78, 0, 1);
    drive(0, 8'h00, 0, 1, 8'h79, 0, 1);
    #6;
    rst = 1'b1;
    #1;
    chk("async_gnt_b", gnt_b, 0);
    chk("async_busy", busy, 0);
    chk("async_sel", sel, 0);
    chk("async_out_valid", out_valid, 0);
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(0, 8'h00, 0, 1, 8'h7A, 0, 1);
    chk("post_rst_gnt_b", gnt_b, 1);
    cycle(0, 8'h00, 0, 1, 8'h7B, 1, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0);
    end
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
